// File: rtl/out_port_fifo_pkg.sv
// Shared definitions for the output-port FIFO: FSM encoding and default sizes.
package out_port_fifo_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefDepth     = 8;
  localparam int unsigned DefCntWidth  = 16;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/out_port_fifo_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and occupancy counter.
// The caller guarantees wr_en only when there is room (or a read in the same cycle)
// and rd_en only when count is non-zero.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned PtrW      = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic [PtrW:0]         count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [PtrW:0]         count_q;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign count   = count_q;

endmodule

// File: rtl/out_port_fifo.sv
// Output-port peripheral: captures processor bus writes into a FIFO, hands them to a
// valid/ready consumer, counts accepted/dropped words and reports done after halt+drain.
module out_port_fifo
  import out_port_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
  input  logic                  clock,
  input  logic                  resetn,      // active-high synchronous reset
  input  logic [DATA_WIDTH-1:0] bus,
  input  logic                  bus_enable,
  input  logic                  halt,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  full,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  accept_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  done
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  state_e                state_q, state_d;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [PtrW:0]         fifo_count;
  logic                  overflow_q;
  logic [CNT_WIDTH-1:0]  accept_q;
  logic [CNT_WIDTH-1:0]  drop_q;

  // Writes are only honoured while running; a simultaneous pop frees the slot for a full FIFO.
  always_comb begin
    push_req = bus_enable && (state_q == StRun);
    pop      = out_valid && out_ready;
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (resetn),
    .wr_en   (push),
    .wr_data (bus),
    .rd_en   (pop),
    .rd_data (head_data),
    .full    (full),
    .count   (fifo_count)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: halt starts draining; DRAIN ends once nothing is left (pushes are blocked there).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (halt) state_d = StDrain;
      StDrain: if (fifo_count == '0) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  // Sticky overflow flag and saturating accept/drop counters.
  always_ff @(posedge clock) begin
    if (resetn) begin
      overflow_q <= 1'b0;
      accept_q   <= '0;
      drop_q     <= '0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      if (push && (accept_q != '1)) accept_q <= accept_q + CNT_WIDTH'(1);
      if (drop && (drop_q != '1))   drop_q   <= drop_q + CNT_WIDTH'(1);
    end
  end

  // Head word is masked while empty so the unreset storage never leaks out.
  always_comb begin
    out_valid = (fifo_count != '0);
    out_data  = out_valid ? head_data : '0;
  end

  assign overflow     = overflow_q;
  assign accept_count = accept_q;
  assign drop_count   = drop_q;
  assign done         = (state_q == StDone);

endmodule
